// File: rtl/fp_add_sequencer.sv
// Control sequencer for the floating-point adder datapath: align, add, normalize, round, renormalize.
// Latency: Done rises 6 cycles after Go is sampled (7 with renormalize, 3 on cancel, 4 on flush, 1 on special).
// Backpressure: none; Go is only sampled in IDLE, and a Go seen while Busy is dropped rather than queued.
//
// Ports:
//   Clock, Reset                    rising-edge clock, synchronous active-high reset
//   Go, SpecialIn                   start request, special-operand bypass
//   ExpDiff, LargeExp, SignA/B      small-ALU difference, larger exponent, operand signs
//   MantSum                         big-ALU magnitude (MSB = carry)
//   RoundMant, RoundExp             rounding hardware results (RoundMant MSB = round overflow)
//   Busy, Done                      status / one-cycle completion pulse
//   ExpSelect, PreShift, SubOp      alignment and add controls
//   SumShiftSelect, NormShift,
//   NormRight, ExpIncrSelect        normalizer / exponent adjust controls
//   RoundEn                         rounding strobe
//   Zero, Inf                       result class, valid from Done until the next accepted Go
module fp_add_sequencer #(
    parameter int EXP_W   = 8,
    parameter int MANT_W  = 23,
    parameter int SHIFT_W = 5
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Go,
    input  logic                 SpecialIn,
    input  logic [EXP_W:0]       ExpDiff,
    input  logic [EXP_W-1:0]     LargeExp,
    input  logic                 SignA,
    input  logic                 SignB,
    input  logic [MANT_W+1:0]    MantSum,
    input  logic [MANT_W+1:0]    RoundMant,
    input  logic [EXP_W-1:0]     RoundExp,
    output logic                 Busy,
    output logic                 Done,
    output logic                 ExpSelect,
    output logic [SHIFT_W-1:0]   PreShift,
    output logic                 SubOp,
    output logic                 SumShiftSelect,
    output logic [SHIFT_W-1:0]   NormShift,
    output logic                 NormRight,
    output logic                 ExpIncrSelect,
    output logic                 RoundEn,
    output logic                 Zero,
    output logic                 Inf
);

    localparam int DW = EXP_W + 1;
    // Largest useful pre-add shift: beyond this every significand bit plus guard/round/sticky is gone.
    localparam logic [EXP_W:0]   PRE_SAT      = DW'(MANT_W + 3);
    localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_MAX_FIN  = {{(EXP_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        st_idle   = 3'd0,
        st_align  = 3'd1,
        st_add    = 3'd2,
        st_norm   = 3'd3,
        st_round  = 3'd4,
        st_check  = 3'd5,
        st_renorm = 3'd6,
        st_done   = 3'd7
    } state_t;

    state_t state_q, state_d;

    logic                 exp_sel_q;
    logic [SHIFT_W-1:0]   pre_shift_q;
    logic                 sub_op_q;
    logic [MANT_W+1:0]    mant_q;
    logic [EXP_W-1:0]     large_exp_q;
    logic                 zero_q;
    logic                 inf_q;

    // Only the overflow bit of the rounded mantissa matters to control; the rest is datapath-only.
    logic unused_round_bits;
    assign unused_round_bits = ^RoundMant[MANT_W:0];

    // Leading-zero count over the significand (hidden bit down to LSB).
    function automatic logic [SHIFT_W-1:0] lzc(input logic [MANT_W:0] v);
        logic [SHIFT_W-1:0] n;
        logic               found;
        n     = '0;
        found = 1'b0;
        for (int i = MANT_W; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + SHIFT_W'(1);
            end
        end
        return n;
    endfunction

    logic [EXP_W:0]       abs_diff;
    logic [SHIFT_W-1:0]   pre_shift_d;
    logic [SHIFT_W-1:0]   norm_lz;
    logic [EXP_W-1:0]     norm_lz_ext;
    logic                 carry;
    logic                 underflow;
    logic                 round_ovf;
    logic                 set_inf;

    always_comb begin
        abs_diff    = ExpDiff[EXP_W] ? (~ExpDiff + DW'(1)) : ExpDiff;
        pre_shift_d = (abs_diff > PRE_SAT) ? SHIFT_W'(MANT_W + 3) : abs_diff[SHIFT_W-1:0];
        norm_lz     = lzc(mant_q[MANT_W:0]);
        norm_lz_ext = EXP_W'(norm_lz);
        carry       = mant_q[MANT_W+1];
        // A left shift that would take the exponent to zero or below is flushed (no denormals).
        underflow   = !carry && (norm_lz_ext >= large_exp_q);
        round_ovf   = RoundMant[MANT_W+1];
        // Overflow on rounding at the largest finite exponent, or a plain all-ones exponent, is infinity.
        set_inf     = round_ovf ? (RoundExp == EXP_MAX_FIN) : (RoundExp == EXP_ALL_ONES);
    end

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) state_q <= st_idle;
        else       state_q <= state_d;
    end

    // Operand latches and result status
    always_ff @(posedge Clock) begin
        if (Reset) begin
            exp_sel_q   <= 1'b0;
            pre_shift_q <= '0;
            sub_op_q    <= 1'b0;
            mant_q      <= '0;
            large_exp_q <= '0;
            zero_q      <= 1'b0;
            inf_q       <= 1'b0;
        end else begin
            case (state_q)
                st_idle: begin
                    if (Go) begin
                        exp_sel_q   <= ExpDiff[EXP_W];
                        pre_shift_q <= pre_shift_d;
                        sub_op_q    <= SignA ^ SignB;
                        zero_q      <= 1'b0;
                        inf_q       <= 1'b0;
                    end
                end
                st_add: begin
                    mant_q      <= MantSum;
                    large_exp_q <= LargeExp;
                    if (MantSum == '0) zero_q <= 1'b1;
                end
                st_norm: begin
                    if (underflow) zero_q <= 1'b1;
                end
                st_check: begin
                    if (set_inf) inf_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next state and Moore-decoded outputs
    always_comb begin
        state_d        = state_q;
        Busy           = (state_q != st_idle);
        Done           = 1'b0;
        ExpSelect      = 1'b0;
        PreShift       = '0;
        SubOp          = 1'b0;
        SumShiftSelect = 1'b0;
        NormShift      = '0;
        NormRight      = 1'b0;
        ExpIncrSelect  = 1'b0;
        RoundEn        = 1'b0;
        Zero           = zero_q;
        Inf            = inf_q;

        // Alignment controls stay stable while the sum is formed and carried through the pipeline.
        if (state_q inside {st_align, st_add, st_norm, st_round, st_check, st_renorm}) begin
            ExpSelect = exp_sel_q;
            PreShift  = pre_shift_q;
            SubOp     = sub_op_q;
        end

        // Normalize controls hold through rounding so the normalizer output feeding it is stable.
        if (state_q inside {st_norm, st_round, st_check}) begin
            if (carry) begin
                NormRight = 1'b1;
                NormShift = SHIFT_W'(1);
            end else begin
                NormShift = norm_lz;
            end
        end

        case (state_q)
            st_idle: begin
                if (Go) state_d = SpecialIn ? st_done : st_align;
            end
            st_align: state_d = st_add;
            st_add: begin
                state_d = (MantSum == '0) ? st_done : st_norm;
            end
            st_norm: begin
                state_d = underflow ? st_done : st_round;
            end
            st_round: begin
                RoundEn = 1'b1;
                state_d = st_check;
            end
            st_check: begin
                state_d = (round_ovf && !set_inf) ? st_renorm : st_done;
            end
            st_renorm: begin
                SumShiftSelect = 1'b1;
                ExpIncrSelect  = 1'b1;
                NormRight      = 1'b1;
                NormShift      = SHIFT_W'(1);
                state_d        = st_done;
            end
            st_done: begin
                Done    = 1'b1;
                state_d = st_idle;
            end
            default: state_d = st_idle;
        endcase
    end

endmodule
